// File: rtl/sim_jtag_tap.sv
// sim_jtag_tap: simulation-side JTAG TAP target.
// The host-driven JTAG pins are oversampled in the system clock domain. The block runs the
// 16-state IEEE 1149.1 TAP controller and implements IR, IDCODE, BYPASS and one user DR.
// The user DR reports each Update-DR to the system as a single-cycle pulse.
// Ports:
//   clock, reset_n          system clock, asynchronous active-low reset
//   jtag_TCK/TMS/TDI/TRSTn  host JTAG pins (asynchronous levels)
//   jtag_TDO_data/driven    TDO bit and its valid flag, launched on TCK falling edges
//   tap_state, ir           current TAP state (IEEE encoding) and current instruction
//   dr_capture_data         value loaded into the user DR on Capture-DR
//   dr_update_valid/data    one-cycle pulse carrying the user DR contents on Update-DR
module sim_jtag_tap #(
  parameter int unsigned         IR_WIDTH = 5,
  parameter logic [31:0]         IDCODE   = 32'h00000001,
  parameter logic [IR_WIDTH-1:0] USER_IR  = 5'h11,
  parameter int unsigned         DR_WIDTH = 41
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                jtag_TCK,
  input  logic                jtag_TMS,
  input  logic                jtag_TDI,
  input  logic                jtag_TRSTn,
  output logic                jtag_TDO_data,
  output logic                jtag_TDO_driven,
  output logic [3:0]          tap_state,
  output logic [IR_WIDTH-1:0] ir,
  input  logic [DR_WIDTH-1:0] dr_capture_data,
  output logic                dr_update_valid,
  output logic [DR_WIDTH-1:0] dr_update_data
);

  localparam logic [IR_WIDTH-1:0] IrIdcode  = IR_WIDTH'(1);
  // Capture-IR loads the mandatory ...01 pattern, which equals the IDCODE code.
  localparam logic [IR_WIDTH-1:0] IrCapture = IR_WIDTH'(2'b01);

  typedef enum logic [3:0] {
    StEx2Dr = 4'h0, StEx1Dr = 4'h1, StShDr  = 4'h2, StPauDr = 4'h3,
    StSelIr = 4'h4, StUpdDr = 4'h5, StCapDr = 4'h6, StSelDr = 4'h7,
    StEx2Ir = 4'h8, StEx1Ir = 4'h9, StShIr  = 4'hA, StPauIr = 4'hB,
    StRti   = 4'hC, StUpdIr = 4'hD, StCapIr = 4'hE, StTlr   = 4'hF
  } tap_state_e;

  // Pin synchronizers; the third TCK stage provides edge detection.
  logic [2:0] tck_q;
  logic [1:0] tms_q, tdi_q, trst_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tck_q  <= '0;
      tms_q  <= '0;
      tdi_q  <= '0;
      trst_q <= 2'b11;
    end else begin
      tck_q  <= {tck_q[1:0], jtag_TCK};
      tms_q  <= {tms_q[0], jtag_TMS};
      tdi_q  <= {tdi_q[0], jtag_TDI};
      trst_q <= {trst_q[0], jtag_TRSTn};
    end
  end

  logic tck_rise, tck_fall, tms_s, tdi_s, trst_s_n;
  assign tck_rise = tck_q[1] & ~tck_q[2];
  assign tck_fall = ~tck_q[1] & tck_q[2];
  assign tms_s    = tms_q[1];
  assign tdi_s    = tdi_q[1];
  assign trst_s_n = trst_q[1];

  tap_state_e          state_q, state_d, state_nxt;
  logic [IR_WIDTH-1:0] ir_q, ir_d, ir_shift_q, ir_shift_d;
  logic [31:0]         idcode_q, idcode_d;
  logic                bypass_q, bypass_d;
  logic [DR_WIDTH-1:0] user_q, user_d, upd_data_q, upd_data_d;
  logic                upd_valid_q, upd_valid_d;
  logic                tdo_data_q, tdo_data_d, tdo_driven_q, tdo_driven_d;

  logic sel_idcode, sel_user, dr_lsb;
  assign sel_idcode = (ir_q == IrIdcode);
  assign sel_user   = (ir_q == USER_IR) && !sel_idcode;
  assign dr_lsb     = sel_idcode ? idcode_q[0] : (sel_user ? user_q[0] : bypass_q);

  // IEEE 1149.1 TAP transitions.
  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      StTlr:   state_nxt = tms_s ? StTlr   : StRti;
      StRti:   state_nxt = tms_s ? StSelDr : StRti;
      StSelDr: state_nxt = tms_s ? StSelIr : StCapDr;
      StCapDr: state_nxt = tms_s ? StEx1Dr : StShDr;
      StShDr:  state_nxt = tms_s ? StEx1Dr : StShDr;
      StEx1Dr: state_nxt = tms_s ? StUpdDr : StPauDr;
      StPauDr: state_nxt = tms_s ? StEx2Dr : StPauDr;
      StEx2Dr: state_nxt = tms_s ? StUpdDr : StShDr;
      StUpdDr: state_nxt = tms_s ? StSelDr : StRti;
      StSelIr: state_nxt = tms_s ? StTlr   : StCapIr;
      StCapIr: state_nxt = tms_s ? StEx1Ir : StShIr;
      StShIr:  state_nxt = tms_s ? StEx1Ir : StShIr;
      StEx1Ir: state_nxt = tms_s ? StUpdIr : StPauIr;
      StPauIr: state_nxt = tms_s ? StEx2Ir : StPauIr;
      StEx2Ir: state_nxt = tms_s ? StUpdIr : StShIr;
      StUpdIr: state_nxt = tms_s ? StSelDr : StRti;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    ir_d         = ir_q;
    ir_shift_d   = ir_shift_q;
    idcode_d     = idcode_q;
    bypass_d     = bypass_q;
    user_d       = user_q;
    upd_data_d   = upd_data_q;
    upd_valid_d  = 1'b0;
    tdo_data_d   = tdo_data_q;
    tdo_driven_d = tdo_driven_q;

    if (!trst_s_n) begin
      // Test reset overrides any concurrent TCK edge.
      state_d      = StTlr;
      ir_d         = IrIdcode;
      tdo_driven_d = 1'b0;
    end else if (tck_rise) begin
      state_d = state_nxt;
      case (state_q)
        StTlr:   ir_d       = IrIdcode;
        StCapIr: ir_shift_d = IrCapture;
        StShIr:  ir_shift_d = {tdi_s, ir_shift_q[IR_WIDTH-1:1]};
        StUpdIr: ir_d       = ir_shift_q;
        StCapDr: begin
          if (sel_idcode)    idcode_d = IDCODE;
          else if (sel_user) user_d   = dr_capture_data;
          else               bypass_d = 1'b0;
        end
        StShDr: begin
          if (sel_idcode)    idcode_d = {tdi_s, idcode_q[31:1]};
          else if (sel_user) user_d   = {tdi_s, user_q[DR_WIDTH-1:1]};
          else               bypass_d = tdi_s;
        end
        StUpdDr: begin
          if (sel_user) begin
            upd_data_d  = user_q;
            upd_valid_d = 1'b1;
          end
        end
        default: ;
      endcase
    end else if (tck_fall) begin
      if (state_q == StShIr) begin
        tdo_data_d   = ir_shift_q[0];
        tdo_driven_d = 1'b1;
      end else if (state_q == StShDr) begin
        tdo_data_d   = dr_lsb;
        tdo_driven_d = 1'b1;
      end else begin
        tdo_driven_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StTlr;
      ir_q         <= IrIdcode;
      ir_shift_q   <= '0;
      idcode_q     <= '0;
      bypass_q     <= 1'b0;
      user_q       <= '0;
      upd_data_q   <= '0;
      upd_valid_q  <= 1'b0;
      tdo_data_q   <= 1'b0;
      tdo_driven_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ir_q         <= ir_d;
      ir_shift_q   <= ir_shift_d;
      idcode_q     <= idcode_d;
      bypass_q     <= bypass_d;
      user_q       <= user_d;
      upd_data_q   <= upd_data_d;
      upd_valid_q  <= upd_valid_d;
      tdo_data_q   <= tdo_data_d;
      tdo_driven_q <= tdo_driven_d;
    end
  end

  assign tap_state       = state_q;
  assign ir              = ir_q;
  assign jtag_TDO_data   = tdo_data_q;
  assign jtag_TDO_driven = tdo_driven_q;
  assign dr_update_valid = upd_valid_q;
  assign dr_update_data  = upd_data_q;

endmodule
